// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - stream-to-AXI burst writer; AXI_BURST_WRITER_4K_SPLIT_EN keeps bursts inside 4KB pages
module axi_burst_writer #(
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int IDWidth        = 1,
    parameter int MaxBurstLen    = 16,
    parameter int FifoDepth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base_addr,
    input  logic [31:0]             total_words,
    input  logic [DataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    resp_err,
    output logic [AddressWidth-1:0] awaddr,
    output logic [IDWidth-1:0]      awid,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DataWidth-1:0]    wdata,
    output logic [DataWidth/8-1:0]  wstrb,
    output logic [IDWidth-1:0]      wid,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [IDWidth-1:0]      bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int Bytes   = DataWidth / 8;
    localparam int SizeLog = $clog2(Bytes);
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CntW    = $clog2(FifoDepth + 1);
    localparam int OstW    = $clog2(MaxOutstanding + 1);
    localparam int LenW    = $clog2(MaxBurstLen + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [31:0]             accepted_q, accepted_d;
    logic [31:0]             total_q, total_d;
    logic [OstW-1:0]         ost_q, ost_d;
    logic                    resp_err_q, resp_err_d;
    logic [LenW-1:0]         len_q, len_d;
    logic [LenW-1:0]         beat_q, beat_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [DataWidth-1:0]    mem_q [FifoDepth];

    logic        push, pop, aw_fire, b_fire;
    logic [31:0] len_c;
    logic        unused_bid;

    assign unused_bid = ^bid;

`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    logic [31:0] to_4k_c;
    assign to_4k_c = (32'h1000 - {20'b0, addr_q[11:0]}) >> SizeLog;
`endif

    always_comb begin
        len_c = (remaining_q < 32'(MaxBurstLen)) ? remaining_q : 32'(MaxBurstLen);
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
        if (to_4k_c < len_c) begin
            len_c = to_4k_c;
        end
`endif
    end

    // Outputs are gated by reset so they drop in the same cycle reset arrives.
    assign busy     = !reset && (state_q != IDLE);
    assign in_ready = busy && (count_q != CntW'(FifoDepth)) && (accepted_q < total_q);
    assign awvalid  = !reset && (state_q == ADDR) && (32'(count_q) >= len_c)
                      && (ost_q < OstW'(MaxOutstanding));
    assign awaddr   = addr_q;
    assign awlen    = 8'(len_c - 32'd1);
    assign awsize   = 3'(SizeLog);
    assign awburst  = 2'b01;
    assign awid     = '0;
    assign wid      = '0;
    assign wstrb    = '1;
    assign wvalid   = !reset && (state_q == DATA);
    assign wdata    = mem_q[rd_ptr_q];
    assign wlast    = wvalid && (beat_q == len_q - LenW'(1));
    assign bready   = !reset;
    assign done     = !reset && (state_q == DRAIN) && (ost_q == '0);
    assign resp_err = !reset && resp_err_q;

    assign push    = in_valid && in_ready;
    assign pop     = wvalid && wready;
    assign aw_fire = awvalid && awready;
    assign b_fire  = bvalid && bready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        total_d     = total_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        accepted_d  = push ? accepted_q + 32'd1 : accepted_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Responses left over from an abandoned job must not underflow the counter.
        case ({aw_fire, b_fire})
            2'b10:   ost_d = ost_q + OstW'(1);
            2'b01:   ost_d = (ost_q != '0) ? ost_q - OstW'(1) : ost_q;
            default: ost_d = ost_q;
        endcase
        resp_err_d = resp_err_q | (b_fire && (bresp != 2'b00) && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    total_d     = total_words;
                    remaining_d = total_words;
                    accepted_d  = 32'd0;
                    resp_err_d  = 1'b0;
                    state_d     = (total_words == 32'd0) ? DRAIN : ADDR;
                end
            end
            ADDR: begin
                if (aw_fire) begin
                    len_d   = LenW'(len_c);
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (pop) begin
                    beat_d = beat_q + LenW'(1);
                    if (wlast) begin
                        addr_d      = addr_q + (AddressWidth'(len_q) << SizeLog);
                        remaining_d = remaining_q - 32'(len_q);
                        state_d     = (remaining_q == 32'(len_q)) ? DRAIN : ADDR;
                    end
                end
            end
            default: begin
                if (ost_q == '0) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            accepted_q  <= '0;
            total_q     <= '0;
            ost_q       <= '0;
            resp_err_q  <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            accepted_q  <= accepted_d;
            total_q     <= total_d;
            ost_q       <= ost_d;
            resp_err_q  <= resp_err_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb/tb_axi_burst_writer.sv - scoreboard bench for axi_burst_writer
module tb_axi_burst_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] total_words = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, busy, done, resp_err;
    logic [31:0] awaddr;
    logic [0:0]  awid, wid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, wlast, wvalid, bready;
    logic        awready = 1'b0;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [0:0]  bid = '0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;

    axi_burst_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .total_words(total_words), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .resp_err(resp_err),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    int chk_cnt = 0, pass_cnt = 0;
    int cyc = 0, aw_cnt = 0, w_cnt = 0, done_cnt = 0;
    int last_b_cyc = 0, done_cyc = 0;
    int b_pending = 0, b_idx = 0, err_idx = -1;
    bit stall = 0, b_hold = 0, src_fire = 0, b_fire = 0;
    logic [39:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic [31:0] src_q[$];
    logic [39:0] ea;
    logic [32:0] ew;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required job completion");
        $fatal(1, "watchdog");
    end

    // Slave and source driver: inputs change 1 time unit after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
        src_fire = 0;
        if (src_q.size() > 0 && (!stall || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
        end
        awready = !stall || ($urandom_range(1) == 1);
        wready  = !stall || ($urandom_range(3) != 0);
        if (b_fire) begin
            bvalid = 1'b0;
            b_fire = 0;
        end
        if (!bvalid && b_pending > 0 && !b_hold && (!stall || $urandom_range(1) == 1)) begin
            bvalid = 1'b1;
            bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
            b_idx++;
            b_pending--;
        end
    end

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    initial forever begin
        @(negedge clk);
        src_fire = in_valid && in_ready;
        if (awvalid && awready) begin
            aw_cnt++;
            chk_cnt++;
            if (exp_aw.size() == 0) begin
                $display("FAIL aw_unexpected: got addr=%h len=%0d, required no burst", awaddr, awlen);
            end else begin
                ea = exp_aw.pop_front();
                if ({awaddr, awlen} !== ea || awsize !== 3'd2 || awburst !== 2'b01 || awid !== 1'b0)
                    $display("FAIL aw: got addr=%h len=%0d size=%0d burst=%0d id=%0d, required addr=%h len=%0d size=2 burst=1 id=0",
                             awaddr, awlen, awsize, awburst, awid, ea[39:8], ea[7:0]);
                else
                    pass_cnt++;
            end
        end
        if (wvalid && wready) begin
            w_cnt++;
            chk_cnt++;
            if (exp_w.size() == 0) begin
                $display("FAIL w_unexpected: got data=%h last=%b, required no beat", wdata, wlast);
            end else begin
                ew = exp_w.pop_front();
                if ({wdata, wlast} !== ew || wstrb !== 4'hf || wid !== 1'b0)
                    $display("FAIL w: got data=%h last=%b strb=%h id=%0d, required data=%h last=%b strb=f id=0",
                             wdata, wlast, wstrb, wid, ew[32:1], ew[0]);
                else
                    pass_cnt++;
            end
            if (wlast) b_pending++;
        end
        if (bvalid && bready) begin
            b_fire = 1;
            last_b_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_burst(input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] d;
        exp_aw.push_back({addr, len});
        for (int i = 0; i <= int'(len); i++) begin
            d = $urandom;
            src_q.push_back(d);
            exp_w.push_back({d, (i == int'(len))});
        end
    endtask

    task automatic load_job(input logic [31:0] base, input int total);
        int rem;
        int l;
        logic [31:0] a;
        rem = total;
        a = base;
        while (rem > 0) begin
            l = (rem < 16) ? rem : 16;
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
            if (int'((32'h1000 - (a & 32'hfff)) / 4) < l) l = int'((32'h1000 - (a & 32'hfff)) / 4);
`endif
            push_burst(a, 8'(l - 1));
            a = a + 32'(l * 4);
            rem -= l;
        end
    endtask

    task automatic start_job(input logic [31:0] b, input int t);
        @(posedge clk);
        #2;
        start = 1'b1;
        base_addr = b;
        total_words = 32'(t);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic await_done(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if ({awvalid, wvalid, wlast, in_ready, busy, done, resp_err, bready} !== 8'b0)
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {awvalid, wvalid, wlast, in_ready, busy, done, resp_err, bready});
        else pass_cnt++;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({bready, busy} !== 2'b10) $display("FAIL post_reset: got bready,busy=%b, required 10", {bready, busy});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int a0, w0, d0;
        bit ok;
        push_burst(32'h1000, 8'd15);
        push_burst(32'h1040, 8'd15);
        push_burst(32'h1080, 8'd7);
        a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
        start_job(32'h1000, 40);
        start_job(32'h9000, 5);
        await_done(400, ok);
        chk_cnt++;
        if (!ok) $display("FAIL basic_done: got no done, required done"); else pass_cnt++;
        chk_cnt++;
        if (aw_cnt - a0 != 3 || w_cnt - w0 != 40)
            $display("FAIL basic_counts: got aw=%0d w=%0d, required aw=3 w=40", aw_cnt - a0, w_cnt - w0);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc - last_b_cyc != 1)
            $display("FAIL basic_done_latency: got %0d, required 1", done_cyc - last_b_cyc);
        else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({busy, done} !== 2'b00 || done_cnt - d0 != 1 || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL basic_after: got busy,done=%b pulses=%0d left=%0d, required 00 1 0",
                     {busy, done}, done_cnt - d0, exp_aw.size() + exp_w.size());
        else pass_cnt++;
    endtask

    task automatic test_4k();
        int a0, n;
        bit ok;
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
        push_burst(32'h0ff8, 8'd1);
        push_burst(32'h1000, 8'd5);
        n = 2;
`else
        push_burst(32'h0ff8, 8'd7);
        n = 1;
`endif
        a0 = aw_cnt;
        start_job(32'h0ff8, 8);
        await_done(200, ok);
        chk_cnt++;
        if (!ok || aw_cnt - a0 != n || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL 4k: got done=%b aw=%0d left=%0d, required 1 %0d 0",
                     ok, aw_cnt - a0, exp_aw.size() + exp_w.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int a0, w0;
        bit ok;
        a0 = aw_cnt; w0 = w_cnt;
        start_job(32'h3000, 0);
        await_done(20, ok);
        chk_cnt++;
        if (!ok || aw_cnt != a0 || w_cnt != w0)
            $display("FAIL zero: got done=%b aw=%0d w=%0d, required 1 0 0", ok, aw_cnt - a0, w_cnt - w0);
        else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL zero_busy: got %b, required 0", busy); else pass_cnt++;
    endtask

    task automatic test_outstanding();
        int a0, w0;
        bit ok;
        b_hold = 1;
        a0 = aw_cnt; w0 = w_cnt;
        load_job(32'h4000, 96);
        start_job(32'h4000, 96);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (aw_cnt - a0 >= 4 && w_cnt - w0 >= 64) break;
        end
        repeat (10) @(negedge clk);
        #1;
        chk_cnt++;
        if (aw_cnt - a0 != 4 || awvalid !== 1'b0)
            $display("FAIL outstanding_limit: got aw=%0d awvalid=%b, required 4 0", aw_cnt - a0, awvalid);
        else pass_cnt++;
        b_hold = 0;
        await_done(600, ok);
        chk_cnt++;
        if (!ok || aw_cnt - a0 != 6 || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL outstanding_finish: got done=%b aw=%0d left=%0d, required 1 6 0",
                     ok, aw_cnt - a0, exp_aw.size() + exp_w.size());
        else pass_cnt++;
    endtask

    task automatic test_resp_err();
        bit ok;
        err_idx = b_idx + 1;
        load_job(32'h5000, 48);
        start_job(32'h5000, 48);
        await_done(400, ok);
        chk_cnt++;
        if (!ok || resp_err !== 1'b1) $display("FAIL resp_err_set: got done=%b err=%b, required 1 1", ok, resp_err);
        else pass_cnt++;
        err_idx = -1;
        load_job(32'h5100, 16);
        start_job(32'h5100, 16);
        @(negedge clk);
        #1;
        chk_cnt++;
        if (resp_err !== 1'b0) $display("FAIL resp_err_clear: got %b, required 0", resp_err); else pass_cnt++;
        await_done(200, ok);
        chk_cnt++;
        if (!ok || resp_err !== 1'b0) $display("FAIL resp_err_clean: got done=%b err=%b, required 1 0", ok, resp_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        stall = 1;
        load_job(32'h6ff0, 37);
        start_job(32'h6ff0, 37);
        await_done(2000, ok);
        chk_cnt++;
        if (!ok || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL stall_job1: got done=%b left=%0d, required 1 0", ok, exp_aw.size() + exp_w.size());
        else pass_cnt++;
        load_job(32'h7000, 5);
        start_job(32'h7000, 5);
        await_done(1000, ok);
        chk_cnt++;
        if (!ok || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL stall_job2: got done=%b left=%0d, required 1 0", ok, exp_aw.size() + exp_w.size());
        else pass_cnt++;
        stall = 0;
    endtask

    task automatic test_wrap();
        bit ok;
        load_job(32'hffff_ffc0, 32);
        start_job(32'hffff_ffc0, 32);
        await_done(300, ok);
        chk_cnt++;
        if (!ok || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL wrap: got done=%b left=%0d, required 1 0", ok, exp_aw.size() + exp_w.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int a0, w0;
        bit ok;
        w0 = w_cnt;
        load_job(32'h2000, 40);
        start_job(32'h2000, 40);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (w_cnt - w0 >= 20) break;
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        src_q.delete();
        b_pending = 0;
        bvalid = 1'b0;
        in_valid = 1'b0;
        b_fire = 0;
        src_fire = 0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({awvalid, wvalid, busy} !== 3'b000)
            $display("FAIL reset_mid: got awvalid,wvalid,busy=%b, required 000", {awvalid, wvalid, busy});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        a0 = aw_cnt;
        load_job(32'h2400, 20);
        start_job(32'h2400, 20);
        await_done(300, ok);
        chk_cnt++;
        if (!ok || aw_cnt - a0 != 2 || exp_aw.size() + exp_w.size() != 0)
            $display("FAIL reset_fresh: got done=%b aw=%0d left=%0d, required 1 2 0",
                     ok, aw_cnt - a0, exp_aw.size() + exp_w.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k();
        test_zero();
        test_outstanding();
        test_resp_err();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_burst_writer.md
AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line:
  AddressWidth, 32, AXI address width.
  DataWidth, 32, data/beat width; multiple of 8.
  IDWidth, 1, AXI ID width.
  MaxBurstLen, 16, max beats per burst, 1..256.
  FifoDepth, 32, input buffer entries, power of two, >= MaxBurstLen.
  MaxOutstanding, 4, max AW issued without B returned.
REQ-002 Ports (name, direction, width, meaning) SHALL be one per line; one clock, reset synchronous active-high:
  clk  in  1  clock.
  reset  in  1  synchronous active-high reset.
  start  in  1  job start pulse.
  base_addr  in  AddressWidth  first byte address, beat-aligned.
  total_words  in  32  beats in the job.
  in_data  in  DataWidth  stream payload.
  in_valid  in  1  payload valid.
  in_ready  out  1  payload accepted.
  busy  out  1  job active.
  done  out  1  one-cycle job-complete pulse.
  resp_err  out  1  sticky: any bresp != 0 this job.
  awaddr/awid/awlen/awsize/awburst/awvalid/awready  AW channel (awready in, rest out).
  wdata/wstrb/wid/wlast/wvalid/wready  W channel (wready in, rest out).
  bid/bresp/bvalid/bready  B channel (bready out, rest in).

Function
REQ-003 FSM states IDLE, ADDR, DATA, DRAIN; start in IDLE latches base_addr and total_words, clears resp_err, -> ADDR (or DRAIN if total_words==0); start outside IDLE ignored.
REQ-004 in_ready SHALL be busy && FIFO not full && accepted_count < total_words; words beyond total_words are never accepted.
REQ-005 Burst length L = min(MaxBurstLen, remaining_words, 4KB clip per REQ-017); awlen = L-1.
REQ-006 ADDR: awvalid asserts only when FIFO occupancy >= L and outstanding < MaxOutstanding; awaddr/awlen stable until awready; on handshake -> DATA.
REQ-007 awsize = log2(DataWidth/8), awburst = 2'b01 (INCR), awid = wid = 0, wstrb = all ones.
REQ-008 DATA: wvalid = 1, wdata = FIFO head; FIFO pops on wvalid && wready; wlast high on beat L only.
REQ-009 After the wlast handshake: addr += L*DataWidth/8, remaining -= L; -> ADDR if remaining > 0, else DRAIN.
REQ-010 outstanding counter +1 on AW handshake, -1 on B handshake, unchanged when both occur the same cycle.
REQ-011 bready SHALL be constant 1 while not in reset; bresp != 0 sets resp_err.
REQ-012 DRAIN: when outstanding == 0, done pulses 1 cycle, -> IDLE; busy = (state != IDLE).
REQ-013 FIFO simultaneous push and pop when full or empty-plus-push SHALL be handled without loss; occupancy never exceeds FifoDepth.
REQ-014 Address arithmetic wraps modulo 2^AddressWidth; no overflow flag.

Reset
REQ-015 reset SHALL force state IDLE, FIFO empty, outstanding 0, and outputs awvalid, wvalid, wlast, in_ready, busy, done, resp_err = 0; bready = 0 during reset.
REQ-016 reset asserted mid-burst SHALL abandon the job with no further AW/W beats; in-flight B responses after reset are accepted and ignored.

Configuration
REQ-017 Macro AXI_BURST_WRITER_4K_SPLIT_EN defined: L additionally clipped to beats remaining before the next 4KB boundary so no burst crosses it; undefined: no clip, crossing permitted.

Verification
REQ-018 base 0x1000, total 40, MaxBurstLen 16, no stalls -> AW lens 15,15,7 at 0x1000,0x1040,0x1080; 40 W beats; done 1 cycle after third B.
REQ-019 4K_SPLIT_EN, base 0x0FF8, total 8 -> bursts awaddr 0x0FF8 awlen 1, awaddr 0x1000 awlen 5; without macro -> single awlen 7.
REQ-020 total 0 -> no AW/W; done pulses; busy low afterward.
REQ-021 bvalid withheld for 10 cycles, total 96, MaxOutstanding 4 -> exactly 4 AW issued then awvalid stays low until first B.
REQ-022 one bresp = 2'b10 among 3 bursts -> resp_err 1 at done; next start clears it.
REQ-023 reset asserted at beat 5 of burst 2 -> awvalid/wvalid 0 next cycle; fresh job afterwards completes correctly.
